muldiv_sequencer: RTL and testbench

//  Sequences the multi-cycle MULT/MULTU/DIV/DIVU units on behalf of the CPU controller.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_watchdog.sv | 52 +++++
 rtl/muldiv_sequencer.sv | 169 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the mul/div sequencer
//
// Purpose : operation select codes, one-hot sequencer states and the small
//           decode helpers shared by the sequencer and its watchdog.
// Ports   : none (package).

package muldiv_pkg;

    // Operation select as delivered by the controller's decoder.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // One-hot sequencer states.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_WRITE = 4'b1000
    } state_e;

    // True for the two divide operations; these are the only ones that
    // can hit the divide-by-zero bypass.
    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Unit start vector, bit order {divu, div, mulu, mul}.
    function automatic logic [3:0] start_decode(input logic [1:0] op);
        logic [3:0] oh;
        oh = 4'b0000;
        case (op)
            OP_MULT:  oh = 4'b0001;
            OP_MULTU: oh = 4'b0010;
            OP_DIV:   oh = 4'b0100;
            OP_DIVU:  oh = 4'b1000;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// rtl/muldiv_watchdog.sv - cycle watchdog bounding the wait for a unit result
//
// Purpose : counts cycles while enabled and flags expiry so the sequencer can
//           abandon a unit that never returns a result.
// Ports   : clk_i     system clock, rising edge
//           rst_i     synchronous active-high reset
//           clear_i   force the count back to zero
//           enable_i  count this cycle
//           expire_o  combinational, high in the last allowed cycle

module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    // Expiry fires in the cycle the count advances to TIMEOUT_CYC-1, so
    // the sequencer leaves WAIT after TIMEOUT_CYC-1 cycles there and the
    // registered abort pulse lands TIMEOUT_CYC cycles after the start pulse.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 2);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - sequences the multi-cycle multiply/divide units
//
// Purpose : accepts one decoded mul/div request, latches operands, pulses the
//           matching unit start, waits (under a watchdog) for the unit result
//           and commits HI/LO in a single write cycle.
// Ports   : clk_i, rst_i                 clock, synchronous active-high reset
//           op_valid_i, op_sel_i         request strobe and operation
//           rs_val_i, rt_val_i           operands A / B
//           opa_o, opb_o                 latched operands to all units
//           mul/mulu/div/divu_start_o    one-cycle unit starts
//           unit_done_i, unit_hi_i/lo_i  result return from the units
//           busy_o                       request in flight
//           hi_ena_o, lo_ena_o           HI/LO write enables
//           hi_out_o, lo_out_o           HI/LO write data
//           done_o                       one-cycle completion pulse
//           err_timeout_o                one-cycle watchdog abort pulse

module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             op_valid_i,
    input  logic [1:0]       op_sel_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic             mul_start_o,
    output logic             mulu_start_o,
    output logic             div_start_o,
    output logic             divu_start_o,
    input  logic             unit_done_i,
    input  logic [WIDTH-1:0] unit_hi_i,
    input  logic [WIDTH-1:0] unit_lo_i,
    output logic             busy_o,
    output logic             hi_ena_o,
    output logic             lo_ena_o,
    output logic [WIDTH-1:0] hi_out_o,
    output logic [WIDTH-1:0] lo_out_o,
    output logic             done_o,
    output logic             err_timeout_o
);

    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] hi_out_q;
    logic [WIDTH-1:0] lo_out_q;
    logic [3:0]       start_q;      // {divu, div, mulu, mul}
    logic             busy_q;
    logic             ena_q;        // HI and LO are always written together
    logic             done_q;
    logic             err_q;

    logic             div_by_zero;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expire;

    // A zero divisor never reaches a divider; the sequencer completes on
    // its own and leaves HI/LO untouched.
    assign div_by_zero = op_is_div(op_q) && (opb_q == '0);

    assign wd_enable = (state_q == S_WAIT);
    assign wd_clear  = (state_q != S_WAIT);

    muldiv_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            hi_out_q <= '0;
            lo_out_q <= '0;
            start_q  <= '0;
            busy_q   <= 1'b0;
            ena_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            start_q <= '0;
            ena_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (op_valid_i) begin
                        op_q    <= op_sel_i;
                        opa_q   <= rs_val_i;
                        opb_q   <= rt_val_i;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                        // The start is decided at accept time so the
                        // registered pulse coincides with the ISSUE cycle.
                        if (!(op_is_div(op_sel_i) && (rt_val_i == '0))) begin
                            start_q <= start_decode(op_sel_i);
                        end
                    end
                end

                S_ISSUE: begin
                    if (div_by_zero) begin
                        done_q  <= 1'b1;
                        state_q <= S_WRITE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // A result arriving in the expiry cycle still wins.
                    if (unit_done_i) begin
                        hi_out_q <= unit_hi_i;
                        lo_out_q <= unit_lo_i;
                        ena_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= S_WRITE;
                    end else if (wd_expire) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_WRITE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign opa_o         = opa_q;
    assign opb_o         = opb_q;
    assign mul_start_o   = start_q[0];
    assign mulu_start_o  = start_q[1];
    assign div_start_o   = start_q[2];
    assign divu_start_o  = start_q[3];
    assign busy_o        = busy_q;
    assign hi_ena_o      = ena_q;
    assign lo_ena_o      = ena_q;
    assign hi_out_o      = hi_out_q;
    assign lo_out_o      = lo_out_q;
    assign done_o        = done_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer

module tb_muldiv_sequencer;

    localparam int W    = 32;
    localparam int T    = 8;
    localparam int MAXC = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic [1:0]    op_sel;
    logic [W-1:0]  rs_val, rt_val;
    logic [W-1:0]  opa, opb;
    logic          mul_start, mulu_start, div_start, divu_start;
    logic          unit_done;
    logic [W-1:0]  unit_hi, unit_lo;
    logic          busy, hi_ena, lo_ena, done, err_timeout;
    logic [W-1:0]  hi_out, lo_out;

    muldiv_sequencer #(.WIDTH(W), .TIMEOUT_CYC(T)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .op_valid_i    (op_valid),
        .op_sel_i      (op_sel),
        .rs_val_i      (rs_val),
        .rt_val_i      (rt_val),
        .opa_o         (opa),
        .opb_o         (opb),
        .mul_start_o   (mul_start),
        .mulu_start_o  (mulu_start),
        .div_start_o   (div_start),
        .divu_start_o  (divu_start),
        .unit_done_i   (unit_done),
        .unit_hi_i     (unit_hi),
        .unit_lo_i     (unit_lo),
        .busy_o        (busy),
        .hi_ena_o      (hi_ena),
        .lo_ena_o      (lo_ena),
        .hi_out_o      (hi_out),
        .lo_out_o      (lo_out),
        .done_o        (done),
        .err_timeout_o (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    logic run = 1'b0;

    // Expected outputs per cycle.
    logic         exp_busy  [MAXC];
    logic [3:0]   exp_start [MAXC];   // {divu, div, mulu, mul}
    logic         exp_done  [MAXC];
    logic         exp_ena   [MAXC];
    logic         exp_err   [MAXC];
    logic [W-1:0] exp_opa   [MAXC];
    logic [W-1:0] exp_opb   [MAXC];
    logic [W-1:0] exp_hi    [MAXC];
    logic [W-1:0] exp_lo    [MAXC];
    // Unit-side stimulus plan.
    logic         plan_done [MAXC];
    logic [W-1:0] plan_hi   [MAXC];
    logic [W-1:0] plan_lo   [MAXC];
    // Observed outputs.
    logic         obs_busy  [MAXC];
    logic [3:0]   obs_start [MAXC];
    logic         obs_done  [MAXC];
    logic [1:0]   obs_ena   [MAXC];
    logic         obs_err   [MAXC];
    logic [W-1:0] obs_hi    [MAXC];
    logic [W-1:0] obs_lo    [MAXC];

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run && cyc >= 1 && cyc < MAXC) begin
            obs_busy[cyc]  = busy;
            obs_start[cyc] = {divu_start, div_start, mulu_start, mul_start};
            obs_done[cyc]  = done;
            obs_ena[cyc]   = {hi_ena, lo_ena};
            obs_err[cyc]   = err_timeout;
            obs_hi[cyc]    = hi_out;
            obs_lo[cyc]    = lo_out;
            chk("busy",   cyc, 32'(busy), 32'(exp_busy[cyc]));
            chk("starts", cyc, 32'({divu_start, div_start, mulu_start, mul_start}), 32'(exp_start[cyc]));
            chk("done",   cyc, 32'(done), 32'(exp_done[cyc]));
            chk("hi_ena", cyc, 32'(hi_ena), 32'(exp_ena[cyc]));
            chk("lo_ena", cyc, 32'(lo_ena), 32'(exp_ena[cyc]));
            chk("err_timeout", cyc, 32'(err_timeout), 32'(exp_err[cyc]));
            chk("opa",    cyc, opa, exp_opa[cyc]);
            chk("opb",    cyc, opb, exp_opb[cyc]);
            chk("hi_out", cyc, hi_out, exp_hi[cyc]);
            chk("lo_out", cyc, lo_out, exp_lo[cyc]);
        end
    end

    // Transaction-level model: from an accepted request, lay out the whole
    // timeline of outputs and the unit response it implies.
    // dly = cycles from start pulse to unit_done; 0 means the unit never answers.
    task automatic model_req(input int n, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int dly, input logic [W-1:0] hi, input logic [W-1:0] lo);
        int s;
        int wr;
        if (exp_busy[n] || rst) return;
        s = n + 1;
        for (int c = s; c < MAXC; c++) begin
            exp_opa[c] = a;
            exp_opb[c] = b;
        end
        if (op[1] && b == '0) begin
            exp_busy[s]     = 1'b1;
            exp_busy[s + 1] = 1'b1;
            exp_done[s + 1] = 1'b1;
        end else begin
            exp_start[s][op] = 1'b1;
            if (dly >= 1 && dly <= T - 1) begin
                plan_done[s + dly] = 1'b1;
                plan_hi[s + dly]   = hi;
                plan_lo[s + dly]   = lo;
                wr = s + dly + 1;
                for (int c = s; c <= wr; c++) exp_busy[c] = 1'b1;
                exp_done[wr] = 1'b1;
                exp_ena[wr]  = 1'b1;
                for (int c = wr; c < MAXC; c++) begin
                    exp_hi[c] = hi;
                    exp_lo[c] = lo;
                end
            end else begin
                for (int c = s; c < s + T; c++) exp_busy[c] = 1'b1;
                exp_err[s + T] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        op_sel    = 2'($urandom_range(0, 3));
        rs_val    = $urandom;
        rt_val    = $urandom;
        unit_done = plan_done[cyc];
        unit_hi   = plan_done[cyc] ? plan_hi[cyc] : $urandom;
        unit_lo   = plan_done[cyc] ? plan_lo[cyc] : $urandom;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int dly, input logic [W-1:0] hi, input logic [W-1:0] lo, output int n);
        n        = cyc;
        op_valid = 1'b1;
        op_sel   = op;
        rs_val   = a;
        rt_val   = b;
        model_req(n, op, a, b, dly, hi, lo);
        tick();
    endtask

    task automatic do_reset(input int k);
        for (int c = cyc + 1; c < MAXC; c++) begin
            exp_busy[c] = 1'b0; exp_start[c] = '0; exp_done[c] = 1'b0;
            exp_ena[c]  = 1'b0; exp_err[c]   = 1'b0;
            exp_opa[c]  = '0;   exp_opb[c]   = '0;
            exp_hi[c]   = '0;   exp_lo[c]    = '0;
        end
        rst = 1'b1;
        repeat (k) tick();
        rst = 1'b0;
    endtask

    function automatic int win_count(input int kind, input int a, input int b);
        int cnt;
        cnt = 0;
        for (int c = a; c <= b; c++) begin
            case (kind)
                0: cnt += int'(obs_done[c]);
                1: cnt += int'(obs_start[c] != 4'b0000);
                2: cnt += int'(obs_busy[c]);
                3: cnt += int'(obs_ena[c] != 2'b00);
                default: cnt += int'(obs_err[c]);
            endcase
        end
        return cnt;
    endfunction

    int n_mult, n_divu, n_dz, n_dzu, n_bnd, n_to, n_rs, n_h, n_dummy;

    initial begin
        for (int c = 0; c < MAXC; c++) begin
            exp_busy[c] = 1'b0; exp_start[c] = '0; exp_done[c] = 1'b0;
            exp_ena[c]  = 1'b0; exp_err[c]   = 1'b0;
            exp_opa[c]  = '0;   exp_opb[c]   = '0;
            exp_hi[c]   = '0;   exp_lo[c]    = '0;
            plan_done[c] = 1'b0; plan_hi[c] = '0; plan_lo[c] = '0;
            obs_busy[c] = 1'b0; obs_start[c] = '0; obs_done[c] = 1'b0;
            obs_ena[c]  = '0;   obs_err[c]   = 1'b0;
            obs_hi[c]   = '0;   obs_lo[c]    = '0;
        end
        rst = 1'b1; op_valid = 1'b0; op_sel = '0; rs_val = '0; rt_val = '0;
        unit_done = 1'b0; unit_hi = '0; unit_lo = '0;
        run = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        req(2'b00, 32'hFFFF_FFFD, 32'd7, 4, 32'hFFFF_FFFF, 32'hFFFF_FFEB, n_mult);
        idle(10);

        plan_done[cyc + 1] = 1'b1;               // stray result during ISSUE
        plan_hi[cyc + 1]   = 32'hDEAD_0001;
        plan_lo[cyc + 1]   = 32'hDEAD_0002;
        req(2'b11, 32'd100, 32'd7, 3, 32'd2, 32'd14, n_divu);
        idle(8);

        plan_done[cyc + 2] = 1'b1;               // stray result while IDLE
        plan_hi[cyc + 2]   = 32'hBAD0_BAD0;
        plan_lo[cyc + 2]   = 32'h0BAD_0BAD;
        idle(4);

        req(2'b10, 32'd55, 32'd0, 3, 32'd1, 32'd1, n_dz);
        idle(5);
        req(2'b11, 32'd9, 32'd0, 3, 32'd1, 32'd1, n_dzu);
        idle(5);

        req(2'b10, 32'hFFFF_FFEC, 32'd3, T - 1, 32'hFFFF_FFFE, 32'hFFFF_FFFA, n_bnd);
        idle(12);

        req(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'd0, 32'd0, n_to);
        idle(14);

        req(2'b00, 32'd5, 32'd6, 5, 32'd0, 32'd30, n_rs);
        idle(2);
        do_reset(1);
        idle(10);

        n_h = cyc;
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      req(2'b00, 32'd11, 32'd13, 1, 32'd0, 32'd143, n_dummy);
            else if (i < 4)  req(2'b10, 32'd5, 32'd0, 1, 32'd0, 32'd0, n_dummy);
            else             req(2'b01, 32'd6, 32'd9, 2, 32'd0, 32'd54, n_dummy);
        end
        idle(10);
        run = 1'b0;

        chk("mult_start_vec",  n_mult + 1, 32'(obs_start[n_mult + 1]), 32'h1);
        chk("mult_start_once", n_mult, win_count(1, n_mult, n_mult + 9), 1);
        chk("mult_hi",         n_mult + 6, obs_hi[n_mult + 6], 32'hFFFF_FFFF);
        chk("mult_lo",         n_mult + 6, obs_lo[n_mult + 6], 32'hFFFF_FFEB);
        chk("mult_done",       n_mult + 6, 32'(obs_done[n_mult + 6]), 32'h1);
        chk("mult_ena",        n_mult + 6, 32'(obs_ena[n_mult + 6]), 32'h3);
        chk("mult_one_done",   n_mult, win_count(0, n_mult, n_mult + 9), 1);
        chk("divu_start_vec",  n_divu + 1, 32'(obs_start[n_divu + 1]), 32'h8);
        chk("divu_done",       n_divu + 5, 32'(obs_done[n_divu + 5]), 32'h1);
        chk("divu_hi",         n_divu + 5, obs_hi[n_divu + 5], 32'd2);
        chk("divu_lo",         n_divu + 5, obs_lo[n_divu + 5], 32'd14);
        chk("dz_busy_cycles",  n_dz, win_count(2, n_dz, n_dz + 4), 2);
        chk("dz_done",         n_dz + 2, 32'(obs_done[n_dz + 2]), 32'h1);
        chk("dz_no_start",     n_dz, win_count(1, n_dz, n_dz + 4), 0);
        chk("dz_no_write",     n_dz, win_count(3, n_dz, n_dz + 4), 0);
        chk("dzu_done",        n_dzu + 2, 32'(obs_done[n_dzu + 2]), 32'h1);
        chk("bnd_done",        n_bnd + 9, 32'(obs_done[n_bnd + 9]), 32'h1);
        chk("bnd_no_timeout",  n_bnd, win_count(4, n_bnd, n_bnd + 11), 0);
        chk("to_err_at_s8",    n_to + 9, 32'(obs_err[n_to + 9]), 32'h1);
        chk("to_busy_after",   n_to + 9, 32'(obs_busy[n_to + 9]), 32'h0);
        chk("to_no_done",      n_to, win_count(0, n_to, n_to + 13), 0);
        chk("to_no_write",     n_to, win_count(3, n_to, n_to + 13), 0);
        chk("rst_busy_after",  n_rs + 4, 32'(obs_busy[n_rs + 4]), 32'h0);
        chk("rst_no_done",     n_rs, win_count(0, n_rs, n_rs + 12), 0);
        chk("rst_no_write",    n_rs, win_count(3, n_rs, n_rs + 12), 0);
        chk("held_min_lat",    n_h + 3, 32'(obs_done[n_h + 3]), 32'h1);
        chk("held_completions", n_h, win_count(0, n_h, n_h + 12), 2);
        chk("held_b2b_start",  n_h + 5, 32'(obs_start[n_h + 5]), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
